// File: rtl/spi_wb_pkg.sv
// Shared constants and state type for the byte-stream Wishbone master.
package spi_wb_pkg;

  localparam logic [7:0] CMD_READ     = 8'hA1;
  localparam logic [7:0] CMD_WRITE    = 8'hA2;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_ERR     = 8'h01;
  localparam logic [7:0] STAT_TIMEOUT = 8'h02;
  localparam logic [7:0] STAT_RETRY   = 8'h03;
  localparam logic [7:0] STAT_BADCMD  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/wb_byte_master.sv
// Byte-stream to Wishbone classic master: parses a command frame, runs one
// bus cycle with a timeout and serializes a status byte plus read data.
module wb_byte_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i
);
  import spi_wb_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    we_q, we_d;
  logic                    stb_q, stb_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [2:0]              rem_q, rem_d;
  logic                    in_ready_q, in_ready_d;
  logic                    in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Next-state logic: frame collection, bus termination and response serializer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    stb_d       = stb_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rem_d       = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          if (in_data == CMD_READ || in_data == CMD_WRITE) begin
            we_d    = (in_data == CMD_WRITE);
            cnt_d   = 2'd0;
            state_d = ST_ADDR;
          end else begin
            out_data_d  = STAT_BADCMD;
            out_valid_d = 1'b1;
            rem_d       = 3'd0;
            state_d     = ST_RESP;
          end
        end
      end

      ST_ADDR: begin
        if (in_fire) begin
          adr_d = {in_data, adr_q[ADDR_WIDTH-1:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_BUS;
              stb_d   = 1'b1;
              tmo_d   = '0;
            end
          end
        end
      end

      ST_DATA: begin
        if (in_fire) begin
          dat_d = {in_data, dat_q[DATA_WIDTH-1:8]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS;
            stb_d   = 1'b1;
            tmo_d   = '0;
          end
        end
      end

      ST_BUS: begin
        if (wbm_err_i || wbm_rty_i || wbm_ack_i || tmo_q == TMO_LAST) begin
          stb_d       = 1'b0;
          out_valid_d = 1'b1;
          rem_d       = 3'd0;
          state_d     = ST_RESP;
          if (wbm_err_i) begin
            out_data_d = STAT_ERR;
          end else if (wbm_rty_i) begin
            out_data_d = STAT_RETRY;
          end else if (wbm_ack_i) begin
            out_data_d = STAT_OK;
            if (!we_q) begin
              rdata_d = wbm_dat_i;
              rem_d   = 3'd4;
            end
          end else begin
            out_data_d = STAT_TIMEOUT;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RESP: begin
        if (out_fire) begin
          if (rem_q != 3'd0) begin
            out_data_d = rdata_q[7:0];
            rdata_d    = {8'h00, rdata_q[DATA_WIDTH-1:8]};
            rem_d      = rem_q - 3'd1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
  end

  // State and datapath registers; reset clears the bus cycle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      rem_q       <= 3'd0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = '1;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = stb_q;

endmodule

// File: tb/tb_wb_byte_master.sv
// Randomized bench for wb_byte_master with a transaction-level model,
// a behavioural Wishbone slave and a per-cycle compare process.
module tb_wb_byte_master;
  import spi_wb_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_rty_i = 1'b0;

  wb_byte_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave behaviour (mode: 0 ack, 1 err, 2 rty, 3 silent, 4 err+ack, 5 rty+ack, 6 err+rty)
  int sl_mode = 0;
  int sl_lat = 1;
  int sl_cnt = 0;
  logic [31:0] slave_mem [16];

  // Model state and expectations for the current frame
  logic [31:0] model_mem [16];
  logic [31:0] exp_adr = 0;
  logic [31:0] exp_dat = 0;
  logic        exp_we = 0;
  int          exp_stb_len = 0;
  int          exp_pulses = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];
  int          stb_pulses = 0;
  int          last_stb_run = 0;
  int          hold_low = 0;
  bit          rand_ready = 0;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Slave responder: terminates on the sl_lat-th cycle of a strobe
  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = $urandom;
    if (!wbm_stb_o) begin
      sl_cnt = 0;
    end else begin
      sl_cnt++;
      if (sl_cnt == sl_lat) begin
        case (sl_mode)
          0: begin
            wbm_ack_i = 1'b1;
            if (wbm_we_o) slave_mem[wbm_adr_o[5:2]] = wbm_dat_o;
            else          wbm_dat_i = slave_mem[wbm_adr_o[5:2]];
          end
          1: wbm_err_i = 1'b1;
          2: wbm_rty_i = 1'b1;
          4: begin wbm_err_i = 1'b1; wbm_ack_i = 1'b1; end
          5: begin wbm_rty_i = 1'b1; wbm_ack_i = 1'b1; end
          6: begin wbm_err_i = 1'b1; wbm_rty_i = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // Response consumer: random or always-ready, with forced stall windows
  always @(posedge clk) begin
    #1;
    if (hold_low > 0) begin
      out_ready = 1'b0;
      hold_low--;
    end else if (rand_ready) begin
      out_ready = 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  // Compare process: checks bus and stream outputs on every falling edge
  bit         prev_stb = 0;
  bit         prev_ov = 0;
  bit         prev_or = 0;
  logic [7:0] prev_od = 0;
  int         stb_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb = 0; prev_ov = 0; prev_or = 0; stb_run = 0;
    end else begin
      checkOutput("cyc_eq_stb", 32'(wbm_cyc_o), 32'(wbm_stb_o));
      checkOutput("sel_all_ones", 32'(wbm_sel_o), 32'hF);
      if (wbm_stb_o) begin
        stb_run++;
        checkOutput("in_ready_in_bus", 32'(in_ready), 0);
        checkOutput("bus_adr", wbm_adr_o, exp_adr);
        checkOutput("bus_we", 32'(wbm_we_o), 32'(exp_we));
        if (exp_we) checkOutput("bus_dat", wbm_dat_o, exp_dat);
      end else if (prev_stb) begin
        checkOutput("stb_cycles", stb_run, exp_stb_len);
        checkOutput("valid_at_bus_end", 32'(out_valid), 1);
        last_stb_run = stb_run;
        stb_pulses++;
        stb_run = 0;
      end
      if (out_valid) checkOutput("in_ready_in_resp", 32'(in_ready), 0);
      if (prev_ov && !prev_or) begin
        checkOutput("stall_valid_hold", 32'(out_valid), 1);
        checkOutput("stall_data_hold", 32'(out_data), 32'(prev_od));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("[TB] FAIL unexpected_byte: actual=0x%0h required=none", out_data);
        end else begin
          checkOutput("resp_byte", 32'(out_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        got_q.push_back(out_data);
      end
      prev_stb = wbm_stb_o;
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_od  = out_data;
    end
  end

  // Transaction model: status from the termination rules, data from model memory
  function automatic logic [7:0] modelStatus(input int mode, input int lat);
    if (mode == 3 || lat > T) return STAT_TIMEOUT;
    if (mode == 1 || mode == 4 || mode == 6) return STAT_ERR;
    if (mode == 2 || mode == 5) return STAT_RETRY;
    return STAT_OK;
  endfunction

  task automatic prepareFrame(input logic [7:0] cmd, input logic [31:0] addr,
                              input logic [31:0] data, input int mode, input int lat);
    logic [7:0] st;
    got_q.delete();
    stb_pulses = 0;
    sl_mode = mode;
    sl_lat  = lat;
    if (cmd == CMD_READ || cmd == CMD_WRITE) begin
      exp_adr = addr;
      exp_we  = (cmd == CMD_WRITE);
      exp_dat = data;
      exp_stb_len = (mode == 3 || lat > T) ? T : lat;
      exp_pulses = 1;
      st = modelStatus(mode, lat);
      exp_q.push_back(st);
      if (st == STAT_OK) begin
        if (cmd == CMD_WRITE) model_mem[addr[5:2]] = data;
        else for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[addr[5:2]][8*i +: 8]);
      end
    end else begin
      exp_pulses = 0;
      exp_q.push_back(STAT_BADCMD);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit acc;
    int g;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    g = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      g++;
      if (g > 200) begin
        n_cmp++; n_fail++;
        $display("[TB] FAIL in_accept: actual=stuck required=accepted");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    int nb;
    logic [7:0] fb [9];
    fb[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      fb[1+i] = addr[8*i +: 8];
      fb[5+i] = data[8*i +: 8];
    end
    nb = (cmd == CMD_WRITE) ? 9 : (cmd == CMD_READ) ? 5 : 1;
    for (int k = 0; k < nb; k++) begin
      sendByte(fb[k]);
      if (nb == 1) begin
        @(negedge clk);
        checkOutput("badcmd_valid_now", 32'(out_valid), 1);
        checkOutput("badcmd_no_cyc", 32'(wbm_cyc_o), 0);
      end
    end
  endtask

  task automatic finishFrame();
    int w = 0;
    while (!(exp_q.size() == 0 && !out_valid) && w < 3000) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= 3000) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL frame_done: actual=pending(%0d bytes) required=complete", exp_q.size());
      exp_q.delete();
    end
    checkOutput("stb_pulses", stb_pulses, exp_pulses);
    checkOutput("in_ready_after", 32'(in_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input int mode, input int lat);
    prepareFrame(cmd, addr, data, mode, lat);
    sendFrame(cmd, addr, data);
    finishFrame();
  endtask

  task automatic checkResp(input string nm, input int n, input logic [39:0] bytes);
    checkOutput({nm, "_len"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size()) checkOutput(nm, 32'(got_q[i]), 32'(bytes[8*i +: 8]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] cmd;
    int mode, lat, r;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = $urandom;
      model_mem[i] = slave_mem[i];
    end

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_stb", 32'(wbm_stb_o), 0);
    checkOutput("rst_we", 32'(wbm_we_o), 0);
    checkOutput("rst_adr", wbm_adr_o, 0);
    checkOutput("rst_dat", wbm_dat_o, 0);
    checkOutput("rst_sel", 32'(wbm_sel_o), 32'hF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    checkOutput("in_ready_first_edge", 32'(in_ready), 1);
    @(posedge clk); #1;

    // LED write then read-back
    $display("[TB] directed write/read");
    applyStimulus(CMD_WRITE, 32'h0, 32'h5, 0, 2);
    checkResp("write_resp", 1, 40'h00);
    checkOutput("model_mem0", model_mem[0], 32'h5);
    checkOutput("slave_mem0", slave_mem[0], 32'h5);
    applyStimulus(CMD_READ, 32'h0, 32'h0, 0, 1);
    checkResp("read_resp", 5, 40'h0000000500);

    // Silent slave
    applyStimulus(CMD_READ, 32'h1234, 32'h0, 3, 1);
    checkResp("timeout_resp", 1, 40'h02);
    checkOutput("timeout_stb_len", last_stb_run, 16);

    // err together with ack on a write
    applyStimulus(CMD_WRITE, 32'h8, 32'h12345678, 4, 2);
    checkResp("err_ack_resp", 1, 40'h01);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_no_more_bus", stb_pulses, 1);

    // Bad command then a normal frame
    applyStimulus(8'h33, 32'h0, 32'h0, 0, 1);
    checkResp("badcmd_resp", 1, 40'hFF);
    applyStimulus(CMD_READ, 32'h0, 32'h0, 0, 3);
    checkResp("after_bad_resp", 5, 40'h0000000500);

    // Boundary latencies around the timeout
    applyStimulus(CMD_WRITE, 32'h10, 32'hA5A5_0F0F, 0, 16);
    checkResp("lat16_resp", 1, 40'h00);
    applyStimulus(CMD_READ, 32'h10, 32'h0, 0, 17);
    checkResp("lat17_resp", 1, 40'h02);

    // Stalled read response
    applyStimulus(CMD_WRITE, 32'h4, 32'hCAFEBABE, 0, 1);
    fork
      applyStimulus(CMD_READ, 32'h4, 32'h0, 0, 3);
      begin
        int w = 0;
        while (got_q.size() < 2 && w < 500) begin @(negedge clk); #1; w++; end
        hold_low = 10;
      end
    join
    checkResp("stall_resp", 5, 40'hCAFEBABE00);

    // Reset in the middle of a bus cycle
    prepareFrame(CMD_READ, 32'h40, 32'h0, 3, 1);
    sendFrame(CMD_READ, 32'h40, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midbus_stb", 32'(wbm_stb_o), 0);
    checkOutput("midbus_cyc", 32'(wbm_cyc_o), 0);
    checkOutput("midbus_out_valid", 32'(out_valid), 0);
    checkOutput("midbus_in_ready", 32'(in_ready), 0);
    checkOutput("midbus_adr", wbm_adr_o, 0);
    checkOutput("midbus_we", 32'(wbm_we_o), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_reset_quiet", 32'(out_valid), 0);
    end
    @(posedge clk); #1;

    // Randomized frames
    $display("[TB] random frames");
    rand_ready = 1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5) mode = 0;
      else if (r == 5) mode = 1;
      else if (r == 6) mode = 2;
      else if (r == 7) mode = 3;
      else if (r == 8) mode = 4;
      else mode = $urandom_range(5, 6);
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 17) : $urandom_range(1, 6);
      r = $urandom_range(0, 9);
      if (r < 5) cmd = CMD_WRITE;
      else if (r < 9) cmd = CMD_READ;
      else begin
        cmd = 8'($urandom);
        if (cmd == CMD_READ || cmd == CMD_WRITE) cmd = 8'h00;
      end
      applyStimulus(cmd, $urandom, $urandom, mode, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_byte_master.md
# wb_byte_master

Wishbone classic single-cycle bus master driven by a byte stream. It sits between the SPI slave byte interface and the Wishbone interconnect, so the host can issue 32-bit reads and writes to on-chip peripherals such as the LED controller, PWM and DSHOT blocks. It parses command frames, runs one bus cycle with a timeout, and returns a status byte plus read data as a byte stream.

## Interface
- DATA_WIDTH, 32: Wishbone data width; fixed at 32.
- ADDR_WIDTH, 32: Wishbone address width; fixed at 32.
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for ack/err/rty after stb rises; must be ≥ 2.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  command byte stream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_data  output  8  response byte stream.
- out_valid  output  1  out_data valid.
- out_ready  input  1  response byte consumed when out_valid && out_ready.
- wbm_adr_o  output  ADDR_WIDTH  bus address.
- wbm_dat_o  output  DATA_WIDTH  write data.
- wbm_dat_i  input  DATA_WIDTH  read data.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  SELECT_WIDTH  byte selects; always all ones.
- wbm_stb_o / wbm_cyc_o  output  1  strobe / cycle; always driven identically.
- wbm_ack_i / wbm_err_i / wbm_rty_i  input  1  slave termination.

## Operation
- Frame format: command byte, 4 address bytes little-endian, then 4 data bytes little-endian (write only).
- Command 0xA1 = read, 0xA2 = write. Any other command byte: no bus cycle; response is the single byte 0xFF.
- States: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: accept the command byte. Read/write goes to ADDR; a bad command goes to RESP with status 0xFF.
  - ADDR: collect 4 bytes using a 2-bit counter. Then go to DATA for a write, or BUS for a read.
  - DATA: collect 4 bytes, then go to BUS.
  - BUS: assert cyc/stb. Terminate on err (status 0x01), rty (0x03), ack (0x00), or timeout (0x02).
  - RESP: emit the status byte. For a successful read, then emit 4 read-data bytes, LSB first. Return to IDLE.
- Termination priority when inputs coincide: err > rty > ack.
- A read that ends in err/rty/timeout returns the status byte only.
- On ack, read data is latched from wbm_dat_i. For writes, wbm_dat_o holds the collected data for the whole BUS state.
- wbm_adr_o, wbm_we_o and wbm_dat_o are registered and stable while stb is high.
- in_ready is high only in IDLE, ADDR and DATA; it is low in BUS and RESP (no pipelining of frames).
- There is no inter-byte timeout. A partial frame waits indefinitely; only reset clears it.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, wbm_sel_o=all ones.
- in_ready rises on the first clk edge after rst_n deasserts.
- cyc/stb rise on the edge that accepts the last frame byte.
- Termination is sampled on each edge while stb=1. cyc/stb drop on that same edge, so stb is high for exactly N cycles, where N = slave latency.
- A slave that acks one cycle after stb gives stb high for 1 cycle. A slave that never terminates gives stb high for exactly TIMEOUT_CYCLES cycles.
- The timeout counter is cleared on entry to BUS, so there is no carry-over between frames.
- out_valid rises on the edge that ends the bus cycle. For a bad command it rises on the edge that accepts the command byte.
- out_data/out_valid hold while out_ready=0. The next byte is presented on the edge after a handshake, so throughput is 1 byte/cycle with out_ready held high.
- in_ready returns high on the edge that consumes the final response byte.
- Reset asserted mid-BUS: cyc/stb drop asynchronously and no response is produced.

## Structure
- Shared package spi_wb_pkg:
  - CMD_READ=8'hA1, CMD_WRITE=8'hA2.
  - STAT_OK=8'h00, STAT_ERR=8'h01, STAT_TIMEOUT=8'h02, STAT_RETRY=8'h03, STAT_BADCMD=8'hFF.
  - State enum typedef.
- No sub-module required. The byte collector, timeout counter and response serializer live inline in the single FSM module.

## Test plan
- Write to a connected LED controller: A2, 00 00 00 00, 05 00 00 00 → one stb pulse with we=1, adr=0, dat=0x5; response 00; LED register=0x5.
- Read back from the same slave: A1, 00 00 00 00 → stb with we=0; response 00 05 00 00 00.
- Silent slave with TIMEOUT_CYCLES=16: read from any address → stb high for exactly 16 cycles; response 02 only.
- err asserted together with ack on a write → response 01; no further bus activity.
- Bad command 0x33 → no cyc; response FF; the next valid frame executes normally.
- out_ready held low for 10 cycles mid-read-response → out_data stable with no byte lost or duplicated. Separately, reset asserted during BUS → cyc/stb low immediately, outputs at reset values.
